// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares one regfile access port between core (C) and debug (D); optional macro RF_BYPASS_EN
module regfile_port_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic        c_we,
    input  logic [4:0]  c_rd,
    input  logic [4:0]  c_rs1,
    input  logic [4:0]  c_rs2,
    input  logic [31:0] c_wdata,
    output logic        c_rvalid,
    output logic [31:0] c_rdata1,
    output logic [31:0] c_rdata2,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [4:0]  d_rd,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic [31:0] d_wdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata1,
    output logic [31:0] d_rdata2,
    output logic        rf_en,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} owner_t;

    owner_t      owner_q, owner_d;
    logic [7:0]  wait_q, wait_d;
    logic        fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic [31:0] fwd_wdata_q, fwd_wdata_d;
    logic [31:0] c_hold1_q, c_hold1_d, c_hold2_q, c_hold2_d;
    logic [31:0] d_hold1_q, d_hold1_d, d_hold2_q, d_hold2_d;

    logic        gnt_c, gnt_d;
    logic [31:0] data1_eff, data2_eff;

    // Grant selection, regfile port mux, wait counter and response bookkeeping
    always_comb begin
        gnt_d    = !rst && d_valid && ((wait_q == MAX_W) || !c_valid);
        gnt_c    = !rst && c_valid && !gnt_d;
        c_ready  = gnt_c;
        d_ready  = gnt_d;

        rf_en    = gnt_c || gnt_d;
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_rs1   = 5'd0;
        rf_rs2   = 5'd0;
        rf_wdata = 32'd0;
        if (gnt_d) begin
            rf_we    = d_we;
            rf_rd    = d_rd;
            rf_rs1   = d_rs1;
            rf_rs2   = d_rs2;
            rf_wdata = d_wdata;
        end else if (gnt_c) begin
            rf_we    = c_we;
            rf_rd    = c_rd;
            rf_rs1   = c_rs1;
            rf_rs2   = c_rs2;
            rf_wdata = c_wdata;
        end

        // Wait counter only counts consecutive refused cycles of a live D request
        wait_d = wait_q;
        if (!d_valid || gnt_d) begin
            wait_d = 8'd0;
        end else if (wait_q != MAX_W) begin
            wait_d = wait_q + 8'd1;
        end

        owner_d = gnt_d ? OWN_D : (gnt_c ? OWN_C : OWN_NONE);

        // Same-cycle read-after-write: capture the write data with the grant
        fwd_wdata_d = rf_wdata;
`ifdef RF_BYPASS_EN
        fwd1_d = rf_we && (rf_rd != 5'd0) && (rf_rs1 == rf_rd);
        fwd2_d = rf_we && (rf_rd != 5'd0) && (rf_rs2 == rf_rd);
`else
        fwd1_d = 1'b0;
        fwd2_d = 1'b0;
`endif

        data1_eff = fwd1_q ? fwd_wdata_q : rf_data1;
        data2_eff = fwd2_q ? fwd_wdata_q : rf_data2;

        // Non-owner ports keep presenting their last read data
        c_hold1_d = c_hold1_q;
        c_hold2_d = c_hold2_q;
        d_hold1_d = d_hold1_q;
        d_hold2_d = d_hold2_q;
        if (owner_q == OWN_C) begin
            c_hold1_d = data1_eff;
            c_hold2_d = data2_eff;
        end
        if (owner_q == OWN_D) begin
            d_hold1_d = data1_eff;
            d_hold2_d = data2_eff;
        end

        // Everything reads as zero while reset is asserted, including an in-flight response
        c_rvalid = !rst && (owner_q == OWN_C);
        d_rvalid = !rst && (owner_q == OWN_D);
        c_rdata1 = rst ? 32'd0 : c_hold1_d;
        c_rdata2 = rst ? 32'd0 : c_hold2_d;
        d_rdata1 = rst ? 32'd0 : d_hold1_d;
        d_rdata2 = rst ? 32'd0 : d_hold2_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            wait_q      <= 8'd0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd_wdata_q <= 32'd0;
            c_hold1_q   <= 32'd0;
            c_hold2_q   <= 32'd0;
            d_hold1_q   <= 32'd0;
            d_hold2_q   <= 32'd0;
        end else begin
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            fwd_wdata_q <= fwd_wdata_d;
            c_hold1_q   <= c_hold1_d;
            c_hold2_q   <= c_hold2_d;
            d_hold1_q   <= d_hold1_d;
            d_hold2_q   <= d_hold2_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - table-driven bench for regfile_port_arbiter with a behavioural regfile
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid, c_ready, c_we, c_rvalid;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [31:0] c_wdata, c_rdata1, c_rdata2;
    logic        d_valid, d_ready, d_we, d_rvalid;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [31:0] d_wdata, d_rdata1, d_rdata2;
    logic        rf_en, rf_we;
    logic [4:0]  rf_rd, rf_rs1, rf_rs2;
    logic [31:0] rf_wdata, rf_data1, rf_data2;

    logic [31:0] regs [32];

    int n_cmp = 0;
    int n_err = 0;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] RAW1 = 32'hA5A5A5A5;
`else
    localparam logic [31:0] RAW1 = 32'h00000001;
`endif

    regfile_port_arbiter #(.MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_rd(c_rd), .c_rs1(c_rs1), .c_rs2(c_rs2),
        .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata1(c_rdata1), .c_rdata2(c_rdata2),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata1(d_rdata1), .d_rdata2(d_rdata2),
        .rf_en(rf_en), .rf_we(rf_we), .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_wdata(rf_wdata), .rf_data1(rf_data1), .rf_data2(rf_data2)
    );

    always #5 clk = ~clk;

    // Behavioural regfile: synchronous reads of pre-edge contents, x0 hardwired to zero
    always @(posedge clk) begin
        if (rf_en) begin
            rf_data1 <= (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];
            rf_data2 <= (rf_rs2 == 5'd0) ? 32'd0 : regs[rf_rs2];
            if (rf_we && rf_rd != 5'd0) regs[rf_rd] <= rf_wdata;
        end
    end

    typedef struct {
        logic        cv, cwe;
        logic [4:0]  crd, crs1, crs2;
        logic [31:0] cwd;
        logic        dv, dwe;
        logic [4:0]  drd, drs1, drs2;
        logic [31:0] dwd;
        logic        e_cr, e_dr, e_en, e_we;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [31:0] e_wd;
        logic        e_crv;
        logic [31:0] e_c1, e_c2;
        logic        e_drv;
        logic [31:0] e_d1, e_d2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_c(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] wd);
        c_valid = v; c_we = we; c_rd = rd; c_rs1 = rs1; c_rs2 = rs2; c_wdata = wd;
    endtask

    task automatic drive_d(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] wd);
        d_valid = v; d_we = we; d_rd = rd; d_rs1 = rs1; d_rs2 = rs2; d_wdata = wd;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic contention(input string tag);
        for (int i = 0; i < 10; i++) begin
            drive_c(1'b1, 1'b0, 5'd0, 5'd5, 5'd6, 32'd0);
            drive_d(1'b1, 1'b0, 5'd0, 5'd6, 5'd5, 32'd0);
            @(negedge clk);
            chk($sformatf("%s c_ready[%0d]", tag, i), 32'(c_ready), 32'(i != 8));
            chk($sformatf("%s d_ready[%0d]", tag, i), 32'(d_ready), 32'(i == 8));
            if (i == 9) begin
                chk($sformatf("%s d_rvalid after force", tag), 32'(d_rvalid), 32'd1);
                chk($sformatf("%s d_rdata1 after force", tag), d_rdata1, 32'h22);
            end
            next_cycle();
        end
        drive_c(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        drive_d(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[5] = 32'h11;
        regs[6] = 32'h22;
        regs[7] = 32'h1;
        rf_data1 = 32'd0;
        rf_data2 = 32'd0;

        vecs[0]  = '{0,0,0,0,0,0,            0,0,0,0,0,0, 0,0,0,0,0,0,0,0,            0,0,0,        0,0,0};
        vecs[1]  = '{1,0,0,5,6,0,            0,0,0,0,0,0, 1,0,1,0,0,5,6,0,            0,0,0,        0,0,0};
        vecs[2]  = '{0,0,0,0,0,0,            0,0,0,0,0,0, 0,0,0,0,0,0,0,0,            1,32'h11,32'h22, 0,0,0};
        vecs[3]  = '{1,1,3,0,0,32'hDEADBEEF, 0,0,0,0,0,0, 1,0,1,1,3,0,0,32'hDEADBEEF, 0,32'h11,32'h22, 0,0,0};
        vecs[4]  = '{0,0,0,0,0,0,            1,0,0,3,5,0, 0,1,1,0,0,3,5,0,            1,0,0,        0,0,0};
        vecs[5]  = '{1,1,0,0,0,32'hFFFFFFFF, 0,0,0,0,0,0, 1,0,1,1,0,0,0,32'hFFFFFFFF, 0,0,0,        1,32'hDEADBEEF,32'h11};
        vecs[6]  = '{1,0,0,0,7,0,            0,0,0,0,0,0, 1,0,1,0,0,0,7,0,            1,0,0,        0,32'hDEADBEEF,32'h11};
        vecs[7]  = '{1,1,7,7,6,32'hA5A5A5A5, 0,0,0,0,0,0, 1,0,1,1,7,7,6,32'hA5A5A5A5, 1,0,1,        0,32'hDEADBEEF,32'h11};
        vecs[8]  = '{1,0,0,6,0,0,            1,0,0,7,3,0, 1,0,1,0,0,6,0,0,            1,RAW1,32'h22, 0,32'hDEADBEEF,32'h11};
        vecs[9]  = '{0,0,0,0,0,0,            0,0,0,0,0,0, 0,0,0,0,0,0,0,0,            1,32'h22,0,   0,32'hDEADBEEF,32'h11};
        vecs[10] = '{0,0,0,0,0,0,            1,0,0,7,0,0, 0,1,1,0,0,7,0,0,            0,32'h22,0,   0,32'hDEADBEEF,32'h11};
        vecs[11] = '{0,0,0,0,0,0,            0,0,0,0,0,0, 0,0,0,0,0,0,0,0,            0,32'h22,0,   1,32'hA5A5A5A5,0};

        // Reset with a pending core request: nothing may be granted
        rst = 1'b1;
        drive_c(1'b1, 1'b0, 5'd0, 5'd5, 5'd6, 32'd0);
        drive_d(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset c_ready", 32'(c_ready), 32'd0);
        chk("reset rf_en", 32'(rf_en), 32'd0);
        chk("reset rf_rs1", 32'(rf_rs1), 32'd0);
        chk("reset c_rvalid", 32'(c_rvalid), 32'd0);
        chk("reset c_rdata1", c_rdata1, 32'd0);
        next_cycle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive_c(vecs[i].cv, vecs[i].cwe, vecs[i].crd, vecs[i].crs1, vecs[i].crs2, vecs[i].cwd);
            drive_d(vecs[i].dv, vecs[i].dwe, vecs[i].drd, vecs[i].drs1, vecs[i].drs2, vecs[i].dwd);
            @(negedge clk);
            chk($sformatf("v%0d c_ready", i),  32'(c_ready),  32'(vecs[i].e_cr));
            chk($sformatf("v%0d d_ready", i),  32'(d_ready),  32'(vecs[i].e_dr));
            chk($sformatf("v%0d rf_en", i),    32'(rf_en),    32'(vecs[i].e_en));
            chk($sformatf("v%0d rf_we", i),    32'(rf_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d rf_rd", i),    32'(rf_rd),    32'(vecs[i].e_rd));
            chk($sformatf("v%0d rf_rs1", i),   32'(rf_rs1),   32'(vecs[i].e_rs1));
            chk($sformatf("v%0d rf_rs2", i),   32'(rf_rs2),   32'(vecs[i].e_rs2));
            chk($sformatf("v%0d rf_wdata", i), rf_wdata,      vecs[i].e_wd);
            chk($sformatf("v%0d c_rvalid", i), 32'(c_rvalid), 32'(vecs[i].e_crv));
            chk($sformatf("v%0d c_rdata1", i), c_rdata1,      vecs[i].e_c1);
            chk($sformatf("v%0d c_rdata2", i), c_rdata2,      vecs[i].e_c2);
            chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_drv));
            chk($sformatf("v%0d d_rdata1", i), d_rdata1,      vecs[i].e_d1);
            chk($sformatf("v%0d d_rdata2", i), d_rdata2,      vecs[i].e_d2);
            next_cycle();
        end

        // Anti-starvation: C wins 8 cycles, D forced on the 9th, C again on the 10th
        contention("cont1");
        next_cycle();

        // Reset mid-operation: build up some wait count, grant C, then reset the next cycle
        for (int i = 0; i < 3; i++) begin
            drive_c(1'b1, 1'b0, 5'd0, 5'd5, 5'd6, 32'd0);
            drive_d(1'b1, 1'b0, 5'd0, 5'd6, 5'd5, 32'd0);
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst c_rvalid", 32'(c_rvalid), 32'd0);
        chk("midrst c_ready", 32'(c_ready), 32'd0);
        chk("midrst d_ready", 32'(d_ready), 32'd0);
        chk("midrst rf_en", 32'(rf_en), 32'd0);
        chk("midrst rf_rs1", 32'(rf_rs1), 32'd0);
        chk("midrst c_rdata1", c_rdata1, 32'd0);
        next_cycle();
        rst = 1'b0;
        drive_c(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        drive_d(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("postrst c_rvalid", 32'(c_rvalid), 32'd0);
        chk("postrst c_rdata1", c_rdata1, 32'd0);
        chk("postrst d_rdata1", d_rdata1, 32'd0);
        next_cycle();

        // Wait counter must have restarted from zero: full 8-cycle refusal again
        contention("cont2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
